pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the EN and bubble/flush inputs of the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers.
- Resolves four hazard sources:
  - load-use hazards;
  - multi-cycle data-memory accesses (req/ack handshake);
  - multi-cycle mul/div in EXE;
  - exceptions taken in MEM.
- Also keeps a free-running stall-cycle counter for performance monitoring.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/hazard_detect_lu.sv | 37 +++
 rtl/pipe_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_pkg
//  Purpose  : Shared definitions for the pipeline hazard controller: the
//             sequencer state encoding and the hard-wired zero register index.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_MD_BUSY  = 2'd2;
    localparam logic [1:0] ST_FLUSH    = 2'd3;

    localparam logic [4:0] REG_ZERO    = 5'd0;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_detect_lu.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_detect_lu
//  Purpose  : Combinational load-use comparator. Flags when the instruction
//             in ID reads a register that a load currently in EXE will write.
//  Ports    : i_id_rs, i_id_rt          source register fields in ID
//             i_id_use_rs, i_id_use_rt  ID instruction actually reads them
//             i_exe_mem_read, i_exe_we  EXE instruction is a load / writes RF
//             i_exe_wreg                EXE destination register
//             o_lu_hazard               load-use hazard present
//  Revision : 1.0  initial release
// ============================================================================
module hazard_detect_lu
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_use_rs,
    input  logic       i_id_use_rt,
    input  logic       i_exe_mem_read,
    input  logic       i_exe_we,
    input  logic [4:0] i_exe_wreg,
    output logic       o_lu_hazard
);

    logic w_rs_match;
    logic w_rt_match;
    logic w_exe_load_wr;

    // Writes to r0 are discarded, so a load targeting r0 never creates a hazard.
    assign w_exe_load_wr = i_exe_mem_read & i_exe_we & (i_exe_wreg != REG_ZERO);
    assign w_rs_match    = i_id_use_rs & (i_id_rs == i_exe_wreg);
    assign w_rt_match    = i_id_use_rt & (i_id_rt == i_exe_wreg);
    assign o_lu_hazard   = w_exe_load_wr & (w_rs_match | w_rt_match);

endmodule : hazard_detect_lu
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Stall/flush sequencer for the 5-stage pipeline. Drives the
//             enables and clears of PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB,
//             resolving exceptions, data-memory waits, multi-cycle mul/div
//             and load-use hazards (in that priority), and counts the cycles
//             in which the PC is held.
//  Ports    : clk, rst                  clock, synchronous active-high reset
//             id_rs/rt, id_use_rs/rt    ID source operands
//             exe_mem_read, exe_we,
//             exe_wreg                  EXE instruction destination info
//             md_start                  EXE instruction is mul/div
//             mem_req, mem_ack          data-memory handshake in MEM
//             exc_taken                 exception/eret committed in MEM
//             *_en                      pipeline register enables
//             if_id_flush, *_bubble     pipeline register clears
//             busy                      sequencer not in RUN
//             stall_cycles              count of cycles with pc_en = 0
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             exe_mem_read,
    input  logic             exe_we,
    input  logic [4:0]       exe_wreg,
    input  logic             md_start,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             exc_taken,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_exe_en,
    output logic             exe_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_exe_bubble,
    output logic             exe_mem_bubble,
    output logic             mem_wb_bubble,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles
);

    // The cycle that launches mul/div is the first of MD_LAT, so the counter
    // is loaded with the number of cycles still to go after it.
    localparam logic [7:0]       c_md_init = 8'(MD_LAT - 1);
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [7:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic w_lu_hazard;
    logic w_mem_stall;

    assign w_mem_stall = mem_req & ~mem_ack;

    hazard_detect_lu u_lu (
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_id_use_rs    (id_use_rs),
        .i_id_use_rt    (id_use_rt),
        .i_exe_mem_read (exe_mem_read),
        .i_exe_we       (exe_we),
        .i_exe_wreg     (exe_wreg),
        .o_lu_hazard    (w_lu_hazard)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            md_cnt_q       <= 8'd0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            md_cnt_q       <= md_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        if (exc_taken) begin
            // An exception abandons any outstanding wait.
            state_d  = ST_FLUSH;
            md_cnt_d = 8'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (w_mem_stall) begin
                        state_d = ST_MEM_WAIT;
                    end else if (md_start) begin
                        state_d  = ST_MD_BUSY;
                        md_cnt_d = c_md_init;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ack) begin
                        state_d = ST_RUN;
                    end
                end
                ST_MD_BUSY: begin
                    // The count keeps running under a memory stall and parks
                    // at 1; leaving is held off until memory is done too.
                    if (md_cnt_q > 8'd1) begin
                        md_cnt_d = md_cnt_q - 8'd1;
                    end else if (!w_mem_stall) begin
                        state_d = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        pc_en          = 1'b1;
        if_id_en       = 1'b1;
        id_exe_en      = 1'b1;
        exe_mem_en     = 1'b1;
        mem_wb_en      = 1'b1;
        if_id_flush    = 1'b0;
        id_exe_bubble  = 1'b0;
        exe_mem_bubble = 1'b0;
        mem_wb_bubble  = 1'b0;
        busy           = (state_q != ST_RUN);

        if (rst) begin
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_exe_en  = 1'b0;
            exe_mem_en = 1'b0;
            mem_wb_en  = 1'b0;
            busy       = 1'b0;
        end else if (exc_taken) begin
            if_id_flush    = 1'b1;
            id_exe_bubble  = 1'b1;
            exe_mem_bubble = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (w_mem_stall) begin
                        pc_en         = 1'b0;
                        if_id_en      = 1'b0;
                        id_exe_en     = 1'b0;
                        exe_mem_en    = 1'b0;
                        mem_wb_bubble = 1'b1;
                    end else if (md_start) begin
                        pc_en          = 1'b0;
                        if_id_en       = 1'b0;
                        id_exe_en      = 1'b0;
                        exe_mem_bubble = 1'b1;
                    end else if (w_lu_hazard) begin
                        pc_en         = 1'b0;
                        if_id_en      = 1'b0;
                        id_exe_bubble = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mem_ack) begin
                        pc_en         = 1'b0;
                        if_id_en      = 1'b0;
                        id_exe_en     = 1'b0;
                        exe_mem_en    = 1'b0;
                        mem_wb_bubble = 1'b1;
                    end
                end
                ST_MD_BUSY: begin
                    if (md_cnt_q > 8'd1) begin
                        pc_en          = 1'b0;
                        if_id_en       = 1'b0;
                        id_exe_en      = 1'b0;
                        exe_mem_bubble = 1'b1;
                    end
                    // A memory stall layers on top of the mul/div hold.
                    if (w_mem_stall) begin
                        pc_en         = 1'b0;
                        if_id_en      = 1'b0;
                        id_exe_en     = 1'b0;
                        exe_mem_en    = 1'b0;
                        mem_wb_bubble = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if_id_flush = 1'b1;
                end
                default: begin
                    if_id_flush = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stall-cycle performance counter
    // ------------------------------------------------------------------
    always_comb begin
        stall_cycles_d = pc_en ? stall_cycles_q : (stall_cycles_q + c_cnt_one);
    end

    assign stall_cycles = stall_cycles_q;

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Self-checking bench for pipe_hazard_ctrl. A behavioural model
//             tracks which hazard episode is in progress and how many stall
//             cycles remain; every cycle the DUT outputs and counter are
//             compared with it, and hand-computed literals pin key cycles.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int MD_LAT = 4;
    localparam int CNT_W  = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs, id_rt, exe_wreg;
    logic             id_use_rs, id_use_rt, exe_mem_read, exe_we;
    logic             md_start, mem_req, mem_ack, exc_taken;
    logic             pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en;
    logic             if_id_flush, id_exe_bubble, exe_mem_bubble, mem_wb_bubble;
    logic             busy;
    logic [CNT_W-1:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    // Model state: which episode is active and what is left of it.
    bit m_mem_wait  = 0;
    bit m_md_active = 0;
    int m_md_left   = 0;   // further mul/div stall cycles still owed
    bit m_flushing  = 0;
    int m_cnt       = 0;

    // Snapshot of the DUT in the most recently sampled cycle.
    logic [9:0]       s_vec;
    logic [CNT_W-1:0] s_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .exe_mem_read(exe_mem_read), .exe_we(exe_we), .exe_wreg(exe_wreg),
        .md_start(md_start), .mem_req(mem_req), .mem_ack(mem_ack), .exc_taken(exc_taken),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_exe_en(id_exe_en),
        .exe_mem_en(exe_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_exe_bubble(id_exe_bubble),
        .exe_mem_bubble(exe_mem_bubble), .mem_wb_bubble(mem_wb_bubble),
        .busy(busy), .stall_cycles(stall_cycles)
    );

    // Output vector order:
    // {pc, if_id, id_exe, exe_mem, mem_wb, if_id_flush, id_bub, exe_bub, wb_bub, busy}
    localparam logic [9:0] V_RST   = 10'b00000_0000_0;
    localparam logic [9:0] V_DEF   = 10'b11111_0000_0;
    localparam logic [9:0] V_DEF_B = 10'b11111_0000_1;

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        exe_mem_read = 0; exe_we = 0; exe_wreg = 0;
        md_start = 0; mem_req = 0; mem_ack = 0; exc_taken = 0;
    endtask

    // One clock cycle: evaluate the model from current inputs, compare at the
    // falling edge, advance the model, then move just past the rising edge.
    task automatic step();
        bit e_pc, e_ifid, e_idexe, e_exmem, e_memwb, e_iff, e_idb, e_exb, e_wbb, e_busy;
        bit n_mem_wait, n_md_active, n_flushing, memst, lu;
        int n_md_left, n_cnt;
        logic [9:0] ev, av;
        @(negedge clk);
        {e_pc, e_ifid, e_idexe, e_exmem, e_memwb} = 5'b11111;
        {e_iff, e_idb, e_exb, e_wbb} = 4'b0000;
        e_busy = m_mem_wait | m_md_active | m_flushing;
        n_mem_wait = m_mem_wait; n_md_active = m_md_active;
        n_md_left = m_md_left; n_flushing = m_flushing; n_cnt = m_cnt;
        memst = mem_req && !mem_ack;
        lu = exe_mem_read && exe_we && (exe_wreg != 0) &&
             ((id_use_rs && id_rs == exe_wreg) || (id_use_rt && id_rt == exe_wreg));
        if (rst) begin
            {e_pc, e_ifid, e_idexe, e_exmem, e_memwb, e_busy} = 6'b0;
            n_mem_wait = 0; n_md_active = 0; n_md_left = 0; n_flushing = 0; n_cnt = 0;
        end else begin
            if (exc_taken) begin
                e_iff = 1; e_idb = 1; e_exb = 1;
                n_flushing = 1; n_mem_wait = 0; n_md_active = 0; n_md_left = 0;
            end else if (m_flushing) begin
                e_iff = 1; n_flushing = 0;
            end else if (m_mem_wait) begin
                if (!mem_ack) begin
                    {e_pc, e_ifid, e_idexe, e_exmem} = 4'b0; e_wbb = 1;
                end else n_mem_wait = 0;
            end else if (m_md_active) begin
                if (m_md_left > 0) begin
                    {e_pc, e_ifid, e_idexe} = 3'b0; e_exb = 1;
                    n_md_left = m_md_left - 1;
                end
                if (memst) begin
                    {e_pc, e_ifid, e_idexe, e_exmem} = 4'b0; e_wbb = 1;
                end
                if (m_md_left == 0 && !memst) n_md_active = 0;
            end else begin
                if (memst) begin
                    {e_pc, e_ifid, e_idexe, e_exmem} = 4'b0; e_wbb = 1;
                    n_mem_wait = 1;
                end else if (md_start) begin
                    {e_pc, e_ifid, e_idexe} = 3'b0; e_exb = 1;
                    n_md_active = 1; n_md_left = MD_LAT - 2;
                end else if (lu) begin
                    e_pc = 0; e_ifid = 0; e_idb = 1;
                end
            end
            if (!e_pc) n_cnt = (m_cnt + 1) % (1 << CNT_W);
        end
        ev = {e_pc, e_ifid, e_idexe, e_exmem, e_memwb, e_iff, e_idb, e_exb, e_wbb, e_busy};
        av = {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
              if_id_flush, id_exe_bubble, exe_mem_bubble, mem_wb_bubble, busy};
        checks++;
        if (av !== ev) begin
            errors++;
            $display("FAIL model_outputs t=%0t got %b expected %b", $time, av, ev);
        end
        checks++;
        if (!rst && stall_cycles !== CNT_W'(m_cnt)) begin
            errors++;
            $display("FAIL model_stall_cycles t=%0t got %0d expected %0d", $time, stall_cycles, m_cnt);
        end
        s_vec = av;
        s_cnt = stall_cycles;
        m_mem_wait = n_mem_wait; m_md_active = n_md_active; m_md_left = n_md_left;
        m_flushing = n_flushing; m_cnt = n_cnt;
        @(posedge clk); #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        @(posedge clk); #1;

        // Reset: all enables low
        step(); lit("reset_outputs", 32'(s_vec), 32'(V_RST));
        step();
        rst = 0;
        step(); lit("after_reset_default", 32'(s_vec), 32'(V_DEF));
        lit("after_reset_count", 32'(s_cnt), 32'd0);

        // Load-use on rs
        exe_mem_read = 1; exe_we = 1; exe_wreg = 8; id_use_rs = 1; id_rs = 8;
        step(); lit("lu_rs_stall", 32'(s_vec), 32'(10'b00111_0100_0));
        clear_inputs();
        step(); lit("lu_one_cycle", 32'(s_vec), 32'(V_DEF));
        // Load to r0 never stalls
        exe_mem_read = 1; exe_we = 1; exe_wreg = 0; id_use_rs = 1; id_rs = 0;
        step(); lit("lu_r0_no_stall", 32'(s_vec), 32'(V_DEF));
        // Load-use on rt
        exe_wreg = 5; id_use_rs = 0; id_rs = 5; id_use_rt = 1; id_rt = 5;
        step(); lit("lu_rt_stall", 32'(s_vec), 32'(10'b00111_0100_0));
        exe_we = 0;
        step(); lit("lu_no_we", 32'(s_vec), 32'(V_DEF));
        clear_inputs();

        // Memory wait for 3 cycles then ack
        mem_req = 1;
        step(); lit("mem_first", 32'(s_vec), 32'(10'b00001_0001_0));
        step(); lit("mem_wait", 32'(s_vec), 32'(10'b00001_0001_1));
        step();
        mem_ack = 1;
        step(); lit("mem_release", 32'(s_vec), 32'(V_DEF_B));
        clear_inputs();
        step(); lit("mem_count", 32'(s_cnt), 32'd5);

        // Mul/div, held md_start
        md_start = 1;
        step(); lit("md_first", 32'(s_vec), 32'(10'b00011_0010_0));
        step(); step(); lit("md_third", 32'(s_vec), 32'(10'b00011_0010_1));
        step(); lit("md_release", 32'(s_vec), 32'(V_DEF_B));
        md_start = 0;
        step(); lit("md_count", 32'(s_cnt), 32'd8);

        // Exception aborts MEM_WAIT
        mem_req = 1;
        step(); step();
        exc_taken = 1;
        step(); lit("exc_abort", 32'(s_vec), 32'(10'b11111_1110_1));
        clear_inputs();
        step(); lit("flush_cycle", 32'(s_vec), 32'(10'b11111_1000_1));
        step(); lit("flush_done", 32'(s_vec), 32'(V_DEF));
        lit("exc_count", 32'(s_cnt), 32'd10);

        // Exception while already in FLUSH keeps flushing
        exc_taken = 1;
        step(); step();
        exc_taken = 0;
        step(); lit("flush_reentered", 32'(s_vec), 32'(10'b11111_1000_1));
        step();

        // Priority: memory wait beats mul/div and load-use
        md_start = 1; mem_req = 1;
        exe_mem_read = 1; exe_we = 1; exe_wreg = 3; id_use_rs = 1; id_rs = 3;
        step(); lit("priority_mem", 32'(s_vec), 32'(10'b00001_0001_0));
        clear_inputs(); mem_req = 1; mem_ack = 1;
        step();
        clear_inputs();
        step(); lit("priority_count", 32'(s_cnt), 32'd11);

        // Memory stall overlapping mul/div defers exit
        md_start = 1;
        step();
        md_start = 0; mem_req = 1;
        step(); lit("md_mem_overlap", 32'(s_vec), 32'(10'b00001_0011_1));
        step();
        step(); lit("md_exit_deferred", 32'(s_vec), 32'(10'b00001_0001_1));
        mem_ack = 1;
        step(); lit("md_mem_release", 32'(s_vec), 32'(V_DEF_B));
        clear_inputs();
        step(); lit("md_mem_count", 32'(s_cnt), 32'd15);

        // Reset in the middle of MD_BUSY
        md_start = 1;
        step();
        md_start = 0;
        step();
        rst = 1;
        step(); lit("rst_mid_md", 32'(s_vec), 32'(V_RST));
        rst = 0;
        step(); lit("rst_recover", 32'(s_vec), 32'(V_DEF));
        lit("rst_count", 32'(s_cnt), 32'd0);

        // Simultaneous req/ack: no stall
        mem_req = 1; mem_ack = 1;
        step(); lit("req_ack_same", 32'(s_vec), 32'(V_DEF));
        clear_inputs();
        step(); lit("req_ack_state", 32'(s_vec), 32'(V_DEF));

        // Long memory wait wraps the 8-bit counter: 258 stalls -> 2
        mem_req = 1;
        for (int i = 0; i < 258; i++) step();
        mem_ack = 1;
        step();
        clear_inputs();
        step(); lit("count_wrap", 32'(s_cnt), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
